// File: rtl/bram_arbiter.sv
// Round-robin arbiter for the shared single-port block RAM, with a dump
// sequencer that streams a fixed address range out for the testbench writer.
//
// state | meaning
// ARB   | grant fetch/data requests, round-robin on contention
// DUMP  | one read per cycle from DUMP_FIRST up to DUMP_LAST
// DRAIN | no access; last dump word is presented, then back to ARB
module bram_arbiter #(
  parameter int unsigned RAM_WIDTH  = 32,
  parameter int unsigned DUMP_FIRST = 0,
  parameter int unsigned DUMP_LAST  = 65535
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 if_req,
  input  logic [15:0]          if_addr,
  output logic                 if_ack,
  output logic                 if_rvalid,
  output logic [RAM_WIDTH-1:0] if_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [15:0]          d_addr,
  input  logic [RAM_WIDTH-1:0] d_wdata,
  output logic                 d_ack,
  output logic                 d_rvalid,
  output logic [RAM_WIDTH-1:0] d_rdata,
  input  logic                 dump_start,
  output logic                 dump_busy,
  output logic                 dump_valid,
  output logic [15:0]          dump_addr,
  output logic [RAM_WIDTH-1:0] dump_data,
  output logic                 dump_done,
  output logic                 ram_enable,
  output logic                 write_enable,
  output logic [15:0]          address,
  output logic [RAM_WIDTH-1:0] input_data,
  input  logic [RAM_WIDTH-1:0] output_data
);

  typedef enum logic [1:0] {ARB, DUMP, DRAIN} state_t;

  // 17 bits so that DUMP_LAST = 65535 is reached without the pointer wrapping
  localparam logic [16:0] FIRST_P = 17'(DUMP_FIRST);
  localparam logic [16:0] LAST_P  = 17'(DUMP_LAST);

  state_t      state_q, state_d;
  logic        prio_d_q, prio_d_d;
  logic        if_pend_q, if_pend_d;
  logic        d_pend_q, d_pend_d;
  logic [16:0] ptr_q, ptr_d;
  logic        dvalid_q, dvalid_d;
  logic [15:0] daddr_q, daddr_d;
  logic        dlast_q, dlast_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ARB;
      prio_d_q  <= 1'b0;
      if_pend_q <= 1'b0;
      d_pend_q  <= 1'b0;
      ptr_q     <= '0;
      dvalid_q  <= 1'b0;
      daddr_q   <= '0;
      dlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_d_q  <= prio_d_d;
      if_pend_q <= if_pend_d;
      d_pend_q  <= d_pend_d;
      ptr_q     <= ptr_d;
      dvalid_q  <= dvalid_d;
      daddr_q   <= daddr_d;
      dlast_q   <= dlast_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    prio_d_d     = prio_d_q;
    ptr_d        = ptr_q;
    if_pend_d    = 1'b0;
    d_pend_d     = 1'b0;
    dvalid_d     = 1'b0;
    daddr_d      = daddr_q;
    dlast_d      = 1'b0;
    if_ack       = 1'b0;
    d_ack        = 1'b0;
    ram_enable   = 1'b0;
    write_enable = 1'b0;
    address      = '0;
    input_data   = '0;

    case (state_q)
      ARB: begin
        if (dump_start) begin
          state_d = DUMP;
          ptr_d   = FIRST_P;
        end else if (if_req && (!d_req || !prio_d_q)) begin
          if_ack     = 1'b1;
          ram_enable = 1'b1;
          address    = if_addr;
          if_pend_d  = 1'b1;
          prio_d_d   = 1'b1;
        end else if (d_req) begin
          d_ack        = 1'b1;
          ram_enable   = 1'b1;
          write_enable = d_we;
          address      = d_addr;
          input_data   = d_wdata;
          d_pend_d     = !d_we;
          prio_d_d     = 1'b0;
        end
      end
      DUMP: begin
        ram_enable = 1'b1;
        address    = ptr_q[15:0];
        ptr_d      = ptr_q + 17'd1;
        dvalid_d   = 1'b1;
        daddr_d    = ptr_q[15:0];
        if (ptr_q == LAST_P) begin
          dlast_d = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: state_d = ARB;
      default: state_d = ARB;
    endcase

    // combinational outputs must read zero for the whole time reset is held
    if (!reset_n) begin
      if_ack       = 1'b0;
      d_ack        = 1'b0;
      ram_enable   = 1'b0;
      write_enable = 1'b0;
      address      = '0;
      input_data   = '0;
    end
  end

  assign if_rvalid  = if_pend_q;
  assign if_rdata   = if_pend_q ? output_data : '0;
  assign d_rvalid   = d_pend_q;
  assign d_rdata    = d_pend_q ? output_data : '0;
  assign dump_busy  = (state_q != ARB);
  assign dump_valid = dvalid_q;
  assign dump_addr  = daddr_q;
  assign dump_data  = dvalid_q ? output_data : '0;
  assign dump_done  = dvalid_q & dlast_q;

endmodule
